// File: rtl/multi_timer_ip.sv
// rtl/multi_timer_ip.sv - multi-channel prescaled down-counting timer with PWM outputs
// Shared sticky status, interrupt mask and synchronous restart across all channels.
module multi_timer_ip #(
   parameter int  NUM_CH  = 4,
   parameter int  CNT_W   = 32,
   parameter int  PRESC_W = 8,
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int ADDR_W  = CH_W + 3
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              sel,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic [NUM_CH-1:0] timeout_o,
   output logic [NUM_CH-1:0] pwm_o,
   output logic              irq_o
);

   logic               page;
   logic [CH_W-1:0]    ch_idx;
   logic [1:0]         reg_sel;
   logic               wr;
   logic               rd;
   logic [NUM_CH-1:0]  start;
   logic [NUM_CH-1:0]  clear;
   logic [NUM_CH-1:0]  en;
   logic [NUM_CH-1:0]  mode;
   logic [NUM_CH-1:0]  presc_en;
   logic [NUM_CH-1:0]  pwm_en;
   logic [NUM_CH-1:0]  expire;
   logic [NUM_CH-1:0]  status;
   logic [NUM_CH-1:0]  irq_en;
   logic [PRESC_W-1:0] div   [NUM_CH];
   logic [CNT_W-1:0]   load  [NUM_CH];
   logic [CNT_W-1:0]   value [NUM_CH];
   logic [CNT_W-1:0]   cmp   [NUM_CH];
   logic [31:0]        rd_val;

   assign page    = addr[ADDR_W-1];
   assign ch_idx  = addr[ADDR_W-2:2];
   assign reg_sel = addr[1:0];
   assign wr      = sel && wr_en;
   assign rd      = sel && rd_en;
   assign start   = (wr && page && reg_sel == 2'd2) ? wdata[NUM_CH-1:0] : '0;
   assign clear   = (wr && page && reg_sel == 2'd0) ? wdata[NUM_CH-1:0] : '0;
   assign irq_o   = |(status & irq_en);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic               sel_ch;
      logic               ctrl_wr;
      logic               stop;
      logic               hit;
      logic               run;
      logic               tick;
      logic               en_q;
      logic               mode_q;
      logic               presc_en_q;
      logic               pwm_en_q;
      logic [PRESC_W-1:0] div_q;
      logic [PRESC_W-1:0] pcnt;
      logic [CNT_W-1:0]   load_q;
      logic [CNT_W-1:0]   value_q;
      logic [CNT_W-1:0]   cmp_q;

      assign sel_ch    = wr && !page && ch_idx == CH_W'(i);
      assign ctrl_wr   = sel_ch && reg_sel == 2'd0;
      assign stop      = ctrl_wr && !wdata[0];
      assign hit       = !presc_en_q || pcnt == div_q;
      // A restart or an EN-clearing write in the same cycle swallows the tick.
      assign run       = en_q && !stop && !start[i];
      assign tick      = run && hit;
      assign expire[i] = tick && value_q == CNT_W'(1);

      always_ff @(posedge clk) begin
         if (!resetn) begin
            en_q       <= 1'b0;
            mode_q     <= 1'b0;
            presc_en_q <= 1'b0;
            pwm_en_q   <= 1'b0;
            div_q      <= '0;
            pcnt       <= '0;
            load_q     <= '0;
            value_q    <= '0;
            cmp_q      <= '0;
         end else begin
            if (ctrl_wr) begin
               en_q       <= wdata[0];
               mode_q     <= wdata[1];
               presc_en_q <= wdata[2];
               pwm_en_q   <= wdata[3];
               div_q      <= wdata[8 +: PRESC_W];
            end
            if (sel_ch && reg_sel == 2'd1) load_q <= wdata[CNT_W-1:0];
            if (sel_ch && reg_sel == 2'd3) cmp_q <= wdata[CNT_W-1:0];
            if (expire[i] && !mode_q) en_q <= 1'b0;
            pcnt <= (run && !hit) ? pcnt + PRESC_W'(1) : '0;
            if (!en_q || start[i]) begin
               value_q <= load_q;
            end else if (tick) begin
               if (value_q == CNT_W'(1)) value_q <= mode_q ? load_q : '0;
               else if (value_q != '0) value_q <= value_q - CNT_W'(1);
            end
         end
      end

      assign en[i]       = en_q;
      assign mode[i]     = mode_q;
      assign presc_en[i] = presc_en_q;
      assign pwm_en[i]   = pwm_en_q;
      assign div[i]      = div_q;
      assign load[i]     = load_q;
      assign value[i]    = value_q;
      assign cmp[i]      = cmp_q;
      assign pwm_o[i]    = en_q && pwm_en_q && (value_q <= cmp_q);
   end

   always_comb begin
      rd_val = '0;
      if (page) begin
         case (reg_sel)
            2'd0:    rd_val[NUM_CH-1:0] = status;
            2'd1:    rd_val[NUM_CH-1:0] = irq_en;
            default: ;
         endcase
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (ch_idx == CH_W'(i)) begin
               case (reg_sel)
                  2'd0: begin
                     rd_val[3:0]         = {pwm_en[i], presc_en[i], mode[i], en[i]};
                     rd_val[8 +: PRESC_W] = div[i];
                  end
                  2'd1:    rd_val[CNT_W-1:0] = load[i];
                  2'd2:    rd_val[CNT_W-1:0] = value[i];
                  default: rd_val[CNT_W-1:0] = cmp[i];
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         status    <= '0;
         irq_en    <= '0;
         timeout_o <= '0;
         rdata     <= '0;
      end else begin
         // Expiry wins over a same-cycle write-one-to-clear.
         status    <= (status & ~clear) | expire;
         timeout_o <= expire;
         if (wr && page && reg_sel == 2'd1) irq_en <= wdata[NUM_CH-1:0];
         if (rd) rdata <= rd_val;
      end
   end

endmodule
